// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides and a WIDTH-cycle shift-add multiplier.
// Define ALU_SEQ_SAT_EN for unsigned saturation of modes 0-3.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MODE_W = 8
) (
    input  logic              emu_clk,
    input  logic              emu_rst,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  c_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_out
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [MODE_W-1:0] M_ADD  = MODE_W'(0);
    localparam logic [MODE_W-1:0] M_SUB  = MODE_W'(1);
    localparam logic [MODE_W-1:0] M_RSUB = MODE_W'(2);
    localparam logic [MODE_W-1:0] M_MUL  = MODE_W'(3);
    localparam logic [MODE_W-1:0] M_SHR  = MODE_W'(4);
    localparam logic [MODE_W-1:0] M_SHL  = MODE_W'(5);
    localparam logic [MODE_W-1:0] M_SHRB = MODE_W'(6);
    localparam logic [MODE_W-1:0] M_ROL  = MODE_W'(7);
    localparam logic [MODE_W-1:0] M_XOR  = MODE_W'(8);

    localparam logic [WIDTH-1:0] WL = WIDTH'(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef ALU_SEQ_SAT_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    state_t state_q, state_d;
    logic   pend_q, pend_d;
    logic   accept;

    logic [WIDTH-1:0]  a_q, b_q;
    logic [MODE_W-1:0] mode_q;
    logic [ACC_W-1:0]  acc_q, mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [WIDTH-1:0] mul_res;

    assign accept = in_valid & in_ready;
    assign rot    = b_q % WL;

`ifdef ALU_SEQ_SAT_EN
    logic [WIDTH:0] sum;
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign mul_res = (|acc_q[ACC_W-1:WIDTH]) ? '1 : acc_q[WIDTH-1:0];
`else
    assign mul_res = acc_q;
`endif

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (mode_q)
`ifdef ALU_SEQ_SAT_EN
            M_ADD:  alu_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            M_SUB:  alu_res = (a_q < b_q) ? '0 : a_q - b_q;
            M_RSUB: alu_res = (b_q < a_q) ? '0 : b_q - a_q;
`else
            M_ADD:  alu_res = a_q + b_q;
            M_SUB:  alu_res = a_q - b_q;
            M_RSUB: alu_res = b_q - a_q;
`endif
            M_MUL:  alu_res = mul_res;
            M_SHR:  alu_res = (b_q >= WL) ? '0 : a_q >> b_q;
            M_SHL:  alu_res = (b_q >= WL) ? '0 : a_q << b_q;
            M_SHRB: alu_res = (a_q >= WL) ? '0 : b_q >> a_q;
            M_ROL:  alu_res = (a_q << rot) | (a_q >> (WL - rot));
            M_XOR:  alu_res = a_q ^ b_q;
            default: alu_err = 1'b1;
        endcase
    end

    // pend marks the one IDLE cycle spent evaluating the latched operands
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = DONE;
                end else if (accept) begin
                    if (mode_in == M_MUL) state_d = MUL;
                    else pend_d = 1'b1;
                end
            end
            MUL:  if (cnt_q == CNT_W'(WIDTH)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            in_ready  <= (state_d == IDLE) && !pend_d;
            out_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            c_out    <= '0;
            err_out  <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= a_in;
                b_q      <= b_in;
                mode_q   <= mode_in;
                acc_q    <= '0;
                mcand_q  <= ACC_W'(a_in);
                mplier_q <= b_in;
                cnt_q    <= '0;
            end
            if (state_q == MUL && cnt_q != CNT_W'(WIDTH)) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            if (state_q == IDLE && pend_q) begin
                c_out   <= alu_res;
                err_out <= alu_err;
            end
            if (state_q == MUL && state_d == DONE) begin
                c_out   <= mul_res;
                err_out <= 1'b0;
            end
        end
    end

endmodule
